// File: rtl/ram_port_arbiter_if.sv
// Client request/response and byte-wide RAM bus bundle for ram_port_arbiter.
// slave: the arbiter's view; master: the client/RAM side (testbench or core).
interface ram_port_arbiter_if #(
    parameter int NUM_CH = 3,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                     flush;
    logic                     io_full;
    logic [NUM_CH-1:0]        req_valid;
    logic [NUM_CH-1:0]        req_ready;
    logic [NUM_CH-1:0]        req_write;
    logic [3*NUM_CH-1:0]      req_size;
    logic [ADDR_W*NUM_CH-1:0] req_addr;
    logic [DATA_W*NUM_CH-1:0] req_wdata;
    logic [NUM_CH-1:0]        rsp_valid;
    logic [DATA_W-1:0]        rsp_rdata;
    logic [ADDR_W-1:0]        ram_addr;
    logic [7:0]               ram_dout;
    logic                     ram_wr;
    logic [7:0]               ram_din;

    modport slave (
        input  flush, io_full, req_valid, req_write, req_size, req_addr, req_wdata, ram_din,
        output req_ready, rsp_valid, rsp_rdata, ram_addr, ram_dout, ram_wr
    );

    modport master (
        output flush, io_full, req_valid, req_write, req_size, req_addr, req_wdata, ram_din,
        input  req_ready, rsp_valid, rsp_rdata, ram_addr, ram_dout, ram_wr
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Byte-serial RAM access controller and arbiter for NUM_CH client channels.
// Each channel has a one-entry slot; accesses of 1..DATA_W/8 bytes are split into
// single-byte RAM cycles (ISSUE drives the byte, WAIT covers the RAM read latency).
// Optional feature macro RAM_ARB_RR_EN: round-robin grant instead of fixed priority.
//
//  state    | meaning
//  ---------+------------------------------------------------------------
//  ST_IDLE  | bus idle, grant the next eligible slot
//  ST_ISSUE | current byte address/data on the RAM bus
//  ST_WAIT  | bus parked at 0; read byte arrives and is captured on exit
//  ST_DONE  | all bytes done; response pulse issued on exit
module ram_port_arbiter #(
    parameter int                NUM_CH     = 3,
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter logic [NUM_CH-1:0] FLUSH_MASK = 3'b011,
    parameter int                IO_HI      = 17,
    parameter int                IO_LO      = 16
) (
    input  logic              clk,
    input  logic              rst,
    ram_port_arbiter_if.slave bus
);
    localparam int NB     = DATA_W / 8;
    localparam int BYTE_W = (NB > 1) ? $clog2(NB) : 1;
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

    state_t              state_q, state_d;
    logic [NUM_CH-1:0]   full_q, full_d;
    logic [NUM_CH-1:0]   s_write_q, s_write_d;
    logic [2:0]          s_size_q  [NUM_CH];
    logic [2:0]          s_size_d  [NUM_CH];
    logic [ADDR_W-1:0]   s_addr_q  [NUM_CH];
    logic [ADDR_W-1:0]   s_addr_d  [NUM_CH];
    logic [DATA_W-1:0]   s_wdata_q [NUM_CH];
    logic [DATA_W-1:0]   s_wdata_d [NUM_CH];
    logic [CH_W-1:0]     act_ch_q, act_ch_d;
    logic                act_write_q, act_write_d;
    logic                act_io_q, act_io_d;
    logic [ADDR_W-1:0]   act_addr_q, act_addr_d;
    logic [BYTE_W-1:0]   act_last_q, act_last_d;
    logic [BYTE_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]   act_wdata_q, act_wdata_d;
    logic [DATA_W-1:0]   act_rdata_q, act_rdata_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [7:0]          ram_dout_q, ram_dout_d;
    logic                ram_wr_q, ram_wr_d;
    logic [NUM_CH-1:0]   rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [NUM_CH-1:0]   s_io, req_io, elig;
    logic                gnt_found;
    logic [CH_W-1:0]     gnt_ch;
    logic                kill;
`ifdef RAM_ARB_RR_EN
    logic [CH_W-1:0]     last_q, last_d;
`endif

    // IO-region decode of held and incoming requests, and grant eligibility
    always_comb begin
        s_io   = '0;
        req_io = '0;
        elig   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            s_io[c]   = &s_addr_q[c][IO_HI:IO_LO];
            req_io[c] = &bus.req_addr[c*ADDR_W+IO_LO +: IO_HI-IO_LO+1];
            elig[c]   = full_q[c] & ~(s_write_q[c] & s_io[c] & bus.io_full);
        end
    end

    // Grant selection; blocked IO writes are skipped rather than stalling the search
    always_comb begin
        int idx;
        idx       = 0;
        gnt_found = 1'b0;
        gnt_ch    = '0;
`ifdef RAM_ARB_RR_EN
        for (int i = 0; i < NUM_CH; i++) begin
            idx = (int'(last_q) + 1 + i) % NUM_CH;
            if (!gnt_found && elig[idx]) begin
                gnt_found = 1'b1;
                gnt_ch    = CH_W'(idx);
            end
        end
`else
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (elig[c]) begin
                gnt_found = 1'b1;
                gnt_ch    = CH_W'(c);
            end
        end
`endif
    end

    // Slot bookkeeping, access sequencing and flush handling
    always_comb begin
        full_d      = full_q;
        s_write_d   = s_write_q;
        s_size_d    = s_size_q;
        s_addr_d    = s_addr_q;
        s_wdata_d   = s_wdata_q;
        state_d     = state_q;
        act_ch_d    = act_ch_q;
        act_write_d = act_write_q;
        act_io_d    = act_io_q;
        act_addr_d  = act_addr_q;
        act_last_d  = act_last_q;
        cnt_d       = cnt_q;
        act_wdata_d = act_wdata_q;
        act_rdata_d = act_rdata_q;
        ram_addr_d  = ram_addr_q;
        ram_dout_d  = ram_dout_q;
        ram_wr_d    = ram_wr_q;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
`ifdef RAM_ARB_RR_EN
        last_d      = last_q;
`endif
        kill = bus.flush && FLUSH_MASK[act_ch_q] && !act_write_q && !act_io_q;

        for (int c = 0; c < NUM_CH; c++) begin
            if (bus.flush && FLUSH_MASK[c] && full_q[c] && !s_write_q[c] && !s_io[c])
                full_d[c] = 1'b0;
            if (bus.req_valid[c] && !full_q[c] &&
                !(bus.flush && FLUSH_MASK[c] && !bus.req_write[c] && !req_io[c])) begin
                full_d[c]    = 1'b1;
                s_write_d[c] = bus.req_write[c];
                s_size_d[c]  = bus.req_size[c*3 +: 3];
                s_addr_d[c]  = bus.req_addr[c*ADDR_W +: ADDR_W];
                s_wdata_d[c] = bus.req_wdata[c*DATA_W +: DATA_W];
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (!bus.flush && gnt_found) begin
                    full_d[gnt_ch] = 1'b0;
                    act_ch_d       = gnt_ch;
                    act_write_d    = s_write_q[gnt_ch];
                    act_io_d       = s_io[gnt_ch];
                    act_addr_d     = s_addr_q[gnt_ch];
                    act_last_d     = BYTE_W'((4'd1 << s_size_q[gnt_ch]) - 4'd1);
                    cnt_d          = '0;
                    act_wdata_d    = s_wdata_q[gnt_ch];
                    act_rdata_d    = '0;
                    ram_addr_d     = s_addr_q[gnt_ch];
                    ram_wr_d       = s_write_q[gnt_ch];
                    ram_dout_d     = s_write_q[gnt_ch] ? s_wdata_q[gnt_ch][7:0] : 8'h00;
                    state_d        = ST_ISSUE;
`ifdef RAM_ARB_RR_EN
                    last_d         = gnt_ch;
`endif
                end
            end
            ST_ISSUE: begin
                ram_addr_d = '0;
                ram_wr_d   = 1'b0;
                ram_dout_d = 8'h00;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (!act_write_q)
                    act_rdata_d[{cnt_q, 3'b000} +: 8] = bus.ram_din;
                if (cnt_q == act_last_q) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d       = cnt_q + 1'b1;
                    act_addr_d  = act_addr_q + 1'b1;
                    act_wdata_d = act_wdata_q >> 8;
                    ram_addr_d  = act_addr_q + 1'b1;
                    ram_wr_d    = act_write_q;
                    ram_dout_d  = act_write_q ? act_wdata_d[7:0] : 8'h00;
                    state_d     = ST_ISSUE;
                end
            end
            ST_DONE: begin
                rsp_valid_d[act_ch_q] = 1'b1;
                if (!act_write_q)
                    rsp_rdata_d = act_rdata_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Rolled-back reads have no architectural effect, so they are dropped mid-flight
        if (state_q != ST_IDLE && kill) begin
            state_d     = ST_IDLE;
            ram_addr_d  = '0;
            ram_wr_d    = 1'b0;
            ram_dout_d  = 8'h00;
            rsp_valid_d = '0;
            rsp_rdata_d = rsp_rdata_q;
        end
    end

    // State and datapath registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            full_q      <= '0;
            act_ch_q    <= '0;
            act_write_q <= 1'b0;
            act_io_q    <= 1'b0;
            act_addr_q  <= '0;
            act_last_q  <= '0;
            cnt_q       <= '0;
            act_wdata_q <= '0;
            act_rdata_q <= '0;
            ram_addr_q  <= '0;
            ram_dout_q  <= 8'h00;
            ram_wr_q    <= 1'b0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
`ifdef RAM_ARB_RR_EN
            last_q      <= CH_W'(NUM_CH - 1);
`endif
        end else begin
            state_q     <= state_d;
            full_q      <= full_d;
            act_ch_q    <= act_ch_d;
            act_write_q <= act_write_d;
            act_io_q    <= act_io_d;
            act_addr_q  <= act_addr_d;
            act_last_q  <= act_last_d;
            cnt_q       <= cnt_d;
            act_wdata_q <= act_wdata_d;
            act_rdata_q <= act_rdata_d;
            ram_addr_q  <= ram_addr_d;
            ram_dout_q  <= ram_dout_d;
            ram_wr_q    <= ram_wr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef RAM_ARB_RR_EN
            last_q      <= last_d;
`endif
        end
    end

    // Slot payload registers; contents are don't-care while the slot is empty
    always_ff @(posedge clk) begin
        s_write_q <= s_write_d;
        s_size_q  <= s_size_d;
        s_addr_q  <= s_addr_d;
        s_wdata_q <= s_wdata_d;
    end

    assign bus.req_ready = ~full_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_dout  = ram_dout_q;
    assign bus.ram_wr    = ram_wr_q;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: byte-wide RAM model with registered read,
// write log, and hand-computed expectations for grant order, timing and flush.
module tb_ram_port_arbiter;
    localparam int NUM_CH = 3;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram_port_arbiter_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ram_port_arbiter #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .FLUSH_MASK(3'b011), .IO_HI(17), .IO_LO(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic logic [7:0] rom(input logic [31:0] a);
        case (a)
            32'h0000_0100: rom = 8'h11;
            32'h0000_0101: rom = 8'h22;
            32'h0000_0102: rom = 8'h33;
            32'h0000_0103: rom = 8'h44;
            32'h0000_0010: rom = 8'h5A;
            32'h0000_0040: rom = 8'h01;
            32'h0000_0041: rom = 8'h02;
            32'h0000_0042: rom = 8'h03;
            32'hFFFF_FFFF: rom = 8'h77;
            32'h0000_0000: rom = 8'h88;
            default:       rom = a[7:0] ^ 8'hC3;
        endcase
    endfunction

    logic [31:0] wlog_a [16];
    logic [7:0]  wlog_d [16];
    int          wcnt = 0;

    always @(posedge clk) begin
        bus.ram_din <= rom(bus.ram_addr);
        if (bus.ram_wr && wcnt < 16) begin
            wlog_a[wcnt] <= bus.ram_addr;
            wlog_d[wcnt] <= bus.ram_dout;
            wcnt         <= wcnt + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int ch, input bit w, input logic [2:0] sz,
                           input logic [31:0] a, input logic [31:0] wd);
        bus.req_valid[ch]          = 1'b1;
        bus.req_write[ch]          = w;
        bus.req_size[ch*3 +: 3]    = sz;
        bus.req_addr[ch*32 +: 32]  = a;
        bus.req_wdata[ch*32 +: 32] = wd;
    endtask

    task automatic wait_rsp(input int limit, output bit found, output logic [2:0] v,
                            output logic [31:0] d, output int at);
        found = 1'b0;
        v     = '0;
        d     = '0;
        at    = 0;
        for (int i = 0; i < limit && !found; i++) begin
            @(negedge clk);
            if (bus.rsp_valid != 3'b000) begin
                found = 1'b1;
                v     = bus.rsp_valid;
                d     = bus.rsp_rdata;
                at    = cyc;
            end
        end
    endtask

    task automatic expect_rsp(input string tag, input logic [2:0] ev, input logic [31:0] ed);
        bit found;
        logic [2:0] v;
        logic [31:0] d;
        int at;
        wait_rsp(40, found, v, d, at);
        check({tag, "_seen"}, 64'(found), 64'd1);
        check({tag, "_ch"}, 64'(v), 64'(ev));
        check({tag, "_data"}, 64'(d), 64'(ed));
    endtask

    initial begin
        bit          found;
        logic [2:0]  v;
        logic [31:0] d;
        int          at;
        int          e0;
        int          w0;

        rst           = 1'b1;
        bus.flush     = 1'b0;
        bus.io_full   = 1'b0;
        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_size  = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // reset state
        check("rst_ready", 64'(bus.req_ready), 64'h7);
        check("rst_wr", 64'(bus.ram_wr), 64'h0);
        check("rst_addr", 64'(bus.ram_addr), 64'h0);
        check("rst_rsp", 64'(bus.rsp_valid), 64'h0);
        check("rst_rdata", 64'(bus.rsp_rdata), 64'h0);

        // ch2 4-byte read at 0x100: timing and byte assembly
        set_req(2, 1'b0, 3'd2, 32'h100, 32'h0);
        @(negedge clk);
        bus.req_valid = '0;
        check("acc_ready_low", 64'(bus.req_ready[2]), 64'h0);
        @(negedge clk);
        e0 = cyc;
        check("e0_addr", 64'(bus.ram_addr), 64'h100);
        check("e0_wr", 64'(bus.ram_wr), 64'h0);
        check("e0_ready_high", 64'(bus.req_ready[2]), 64'h1);
        @(negedge clk);
        check("wait_addr", 64'(bus.ram_addr), 64'h0);
        @(negedge clk);
        check("byte1_addr", 64'(bus.ram_addr), 64'h101);
        wait_rsp(40, found, v, d, at);
        check("rd4_seen", 64'(found), 64'd1);
        check("rd4_latency", 64'(at - e0), 64'd9);
        check("rd4_ch", 64'(v), 64'h4);
        check("rd4_data", 64'(d), 64'h4433_2211);
        @(negedge clk);
        check("rsp_pulse", 64'(bus.rsp_valid), 64'h0);

        // ch0 and ch1 competing, ch0 re-requests as soon as it is granted
        set_req(0, 1'b0, 3'd0, 32'h40, 32'h0);
        set_req(1, 1'b0, 3'd0, 32'h42, 32'h0);
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        check("arb_ready0", 64'(bus.req_ready[0]), 64'h1);
        set_req(0, 1'b0, 3'd0, 32'h41, 32'h0);
        @(negedge clk);
        bus.req_valid = '0;
`ifdef RAM_ARB_RR_EN
        expect_rsp("arb1", 3'b001, 32'h01);
        expect_rsp("arb2", 3'b010, 32'h03);
        expect_rsp("arb3", 3'b001, 32'h02);
`else
        expect_rsp("arb1", 3'b001, 32'h01);
        expect_rsp("arb2", 3'b001, 32'h02);
        expect_rsp("arb3", 3'b010, 32'h03);
`endif

        // IO write blocked by io_full is skipped in favour of ch1
        w0 = wcnt;
        bus.io_full = 1'b1;
        set_req(0, 1'b1, 3'd0, 32'h0003_0000, 32'hA5);
        set_req(1, 1'b0, 3'd0, 32'h10, 32'h0);
        @(negedge clk);
        bus.req_valid = '0;
        expect_rsp("io_skip", 3'b010, 32'h5A);
        repeat (3) @(negedge clk);
        check("io_blocked_nowr", 64'(wcnt - w0), 64'd0);
        bus.io_full = 1'b0;
        expect_rsp("io_release", 3'b001, 32'h5A);
        check("io_wr_cnt", 64'(wcnt - w0), 64'd1);
        check("io_wr_addr", 64'(wlog_a[w0]), 64'h0003_0000);
        check("io_wr_data", 64'(wlog_d[w0]), 64'hA5);

        // flush aborts an active masked non-IO read
        set_req(1, 1'b0, 3'd2, 32'h200, 32'h0);
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        check("fl_e0_addr", 64'(bus.ram_addr), 64'h200);
        repeat (2) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("fl_abort_wr", 64'(bus.ram_wr), 64'h0);
        check("fl_abort_addr", 64'(bus.ram_addr), 64'h0);
        wait_rsp(20, found, v, d, at);
        check("fl_no_rsp", 64'(found), 64'd0);
        check("fl_ready", 64'(bus.req_ready), 64'h7);

        // flush drops a pending masked read slot but not the unmasked ch2 access
        set_req(2, 1'b0, 3'd2, 32'h100, 32'h0);
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        set_req(0, 1'b0, 3'd0, 32'h50, 32'h0);
        @(negedge clk);
        bus.req_valid = '0;
        check("fl_slot_full", 64'(bus.req_ready[0]), 64'h0);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("fl_slot_clear", 64'(bus.req_ready[0]), 64'h1);
        expect_rsp("fl_ch2", 3'b100, 32'h4433_2211);
        wait_rsp(10, found, v, d, at);
        check("fl_slot_no_rsp", 64'(found), 64'd0);

        // flush during a 4-byte write: write completes in full
        w0 = wcnt;
        set_req(0, 1'b1, 3'd2, 32'h300, 32'hDDCC_BBAA);
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        check("wr_e0_wr", 64'(bus.ram_wr), 64'h1);
        check("wr_e0_dout", 64'(bus.ram_dout), 64'hAA);
        repeat (2) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        expect_rsp("wr_fl", 3'b001, 32'h4433_2211);
        check("wr_fl_cnt", 64'(wcnt - w0), 64'd4);
        check("wr_fl_bytes", 64'({wlog_d[w0+3], wlog_d[w0+2], wlog_d[w0+1], wlog_d[w0]}), 64'hDDCC_BBAA);
        check("wr_fl_addr0", 64'(wlog_a[w0]), 64'h300);
        check("wr_fl_addr3", 64'(wlog_a[w0+3]), 64'h303);

        // address increment wraps at the top of the address space
        set_req(2, 1'b0, 3'd1, 32'hFFFF_FFFF, 32'h0);
        @(negedge clk);
        bus.req_valid = '0;
        expect_rsp("wrap", 3'b100, 32'h0000_8877);

        // reset mid-access: no response, idle bus
        set_req(1, 1'b0, 3'd2, 32'h200, 32'h0);
        @(negedge clk);
        bus.req_valid = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_ready", 64'(bus.req_ready), 64'h7);
        check("mid_rst_addr", 64'(bus.ram_addr), 64'h0);
        check("mid_rst_rdata", 64'(bus.rsp_rdata), 64'h0);
        wait_rsp(15, found, v, d, at);
        check("mid_rst_no_rsp", 64'(found), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
